// File: rtl/wb_interconnect_nx.sv
// wb_interconnect_nx: 1-master / N-slave Wishbone classic interconnect with base/mask decode and error responses.
// Define WB_INTERCONNECT_NX_TIMEOUT_EN to add a slave-response watchdog (TIMEOUT_CYC cycles).
module wb_interconnect_nx #(
  parameter int NUM_SLV = 4,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
`ifdef WB_INTERCONNECT_NX_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wbm_stb,
  input  logic                   i_wbm_cyc,
  input  logic                   i_wbm_we,
  input  logic [3:0]             i_wbm_sel,
  input  logic [31:0]            i_wbm_adr,
  input  logic [31:0]            i_wbm_dat,
  output logic                   o_wbs_ack,
  output logic                   o_wbs_err,
  output logic [31:0]            o_wbs_dat,
  output logic [NUM_SLV-1:0]     o_slv_cyc,
  output logic [NUM_SLV-1:0]     o_slv_stb,
  output logic                   o_slv_we,
  output logic [3:0]             o_slv_sel,
  output logic [31:0]            o_slv_adr,
  output logic [31:0]            o_slv_dat,
  input  logic [NUM_SLV-1:0]     i_slv_ack,
  input  logic [32*NUM_SLV-1:0]  i_slv_dat,
  output logic [7:0]             o_dec_err_cnt
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, hit_idx;
  logic hit, req, ack, tmo, err;
  assign req = i_wbm_cyc & i_wbm_stb;
  assign ack = i_slv_ack[idx];
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((i_wbm_adr & SLV_MASK[32*i+:32]) == (SLV_BASE[32*i+:32] & SLV_MASK[32*i+:32])) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
  end
`ifdef WB_INTERCONNECT_NX_TIMEOUT_EN
  logic [15:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= (state == REQ) ? cnt + 16'd1 : '0;
  assign tmo = (state == REQ) && (cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? (hit ? REQ : RESP) : IDLE;
      REQ:     state_nx = ack ? RESP : !i_wbm_cyc ? IDLE : tmo ? RESP : REQ;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    o_slv_cyc = (state == REQ) ? NUM_SLV'(1) << idx : '0;
    o_slv_stb = o_slv_cyc;
    o_wbs_ack = state == RESP;
    o_wbs_err = o_wbs_ack & err;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      idx <= '0;
      o_slv_we <= 1'b0;
      o_slv_sel <= '0;
      o_slv_adr <= '0;
      o_slv_dat <= '0;
      o_wbs_dat <= '0;
      err <= 1'b0;
      o_dec_err_cnt <= '0;
    end else begin
      if (state == IDLE && req && hit) begin
        idx <= hit_idx;
        o_slv_we <= i_wbm_we;
        o_slv_sel <= i_wbm_sel;
        o_slv_adr <= i_wbm_adr;
        o_slv_dat <= i_wbm_dat;
      end
      if (state == IDLE && req && !hit) begin
        o_wbs_dat <= ERR_DATA;
        err <= 1'b1;
        o_dec_err_cnt <= (o_dec_err_cnt == 8'hFF) ? o_dec_err_cnt : o_dec_err_cnt + 8'd1;
      end
      if (state == REQ && ack) begin
        o_wbs_dat <= o_slv_we ? '0 : i_slv_dat[32*idx+:32];
        err <= 1'b0;
      end else if (state == REQ && i_wbm_cyc && tmo) begin
        o_wbs_dat <= ERR_DATA;
        err <= 1'b1;
      end
    end
endmodule

// File: doc/wb_interconnect_nx.md
Name: wb_interconnect_nx

Overview:
Parametrised 1-master / N-slave Wishbone classic interconnect. It is the successor to the fixed single-slave interconnect behind the picorv32_wb core.
- Decodes the master address against per-slave base/mask pairs.
- Registers the request toward the selected slave and registers the response back to the master.
- Answers unmapped addresses (and, optionally, hung slaves) with an error response so the CPU never stalls.

Parameters:
NUM_SLV, 4, number of slave ports (1..16)
SLV_BASE, {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}, packed 32*NUM_SLV base addresses; slave i uses bits [32*i+:32]
SLV_MASK, {4{32'hF000_0000}}, packed 32*NUM_SLV decode masks
ERR_DATA, 32'hDEAD_BEEF, read data returned on any error response
TIMEOUT_CYC, 255, slave-response watchdog limit in cycles (optional feature only; 1..65535)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_wbm_stb  in  1  master strobe
i_wbm_cyc  in  1  master cycle
i_wbm_we  in  1  master write enable
i_wbm_sel  in  4  master byte selects
i_wbm_adr  in  32  master address
i_wbm_dat  in  32  master write data
o_wbs_ack  out  1  ack to master, one-cycle pulse
o_wbs_err  out  1  error flag to master, coincident with o_wbs_ack
o_wbs_dat  out  32  read data to master
o_slv_cyc  out  NUM_SLV  per-slave cycle
o_slv_stb  out  NUM_SLV  per-slave strobe
o_slv_we  out  1  shared write enable
o_slv_sel  out  4  shared byte selects
o_slv_adr  out  32  shared address
o_slv_dat  out  32  shared write data
i_slv_ack  in  NUM_SLV  per-slave ack
i_slv_dat  in  32*NUM_SLV  packed per-slave read data
o_dec_err_cnt  out  8  saturating count of decode errors

Behaviour:
- Clocking and reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: every output is 0, and the FSM is in IDLE. Reset asserted mid-transaction aborts the transaction immediately; no ack is ever produced for it.
- Decode: hit[i] = ((i_wbm_adr & MASK_i) == (BASE_i & MASK_i)). If several slaves hit, the lowest index wins. No hit is a decode error.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Sampled i_wbm_cyc & i_wbm_stb with a hit: latch slave index, we, sel, adr, dat; go to REQ.
  - Same request with no hit: go to RESP with err=1, dat=ERR_DATA; o_dec_err_cnt += 1, saturating at 255.
- REQ:
  - o_slv_cyc[idx] = o_slv_stb[idx] = 1; all other bits are 0. The shared buses hold the latched values.
  - i_slv_ack[idx] = 1: capture i_slv_dat[idx] (zero it for writes); go to RESP with err=0. Slave strobes drop on the same edge.
  - i_wbm_cyc = 0: abort; drop strobes, go to IDLE, no ack.
  - Acks from non-selected slaves are ignored.
- RESP: o_wbs_ack = 1 for exactly one cycle, with o_wbs_err and o_wbs_dat valid in that cycle; go to IDLE. o_wbs_dat holds its last value in all other cycles.
- Latency: request sampled at edge 0, slave strobe visible in cycle 1. With a zero-wait slave, o_wbs_ack is high in cycle 2. A decode error gives o_wbs_ack in cycle 1.
- Back-to-back: a new request is accepted in the IDLE cycle right after RESP. The master must deassert stb after seeing ack, as picorv32_wb does.
- Slave write data and selects pass through unmodified; no byte-lane reformatting.

Optional Feature:
Macro WB_INTERCONNECT_NX_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to REQ and increments each REQ cycle. On reaching TIMEOUT_CYC without ack:
  - strobes drop;
  - the FSM goes to RESP with err=1, dat=ERR_DATA.
- Ack and timeout on the same cycle: the ack wins.
- Not defined: no counter; REQ waits indefinitely for ack or master abort. TIMEOUT_CYC is unused.

Test Plan:
- Read 0x1000_0004, slave1 acks in its first strobe cycle with 0x1234_5678 -> o_slv_stb=4'b0010 in cycle 1; o_wbs_ack=1, o_wbs_dat=0x1234_5678, err=0 in cycle 2.
- Write 0x3000_0010, sel=4'b0011, dat=0xA5A5_A5A5, slave3 acks after 3 wait cycles -> slave buses carry exact values; one ack pulse, err=0.
- Access 0x5000_0000 (unmapped) three times -> each gives ack with err=1, dat=0xDEAD_BEEF in cycle 1; o_dec_err_cnt=3; no o_slv_stb.
- Overlapping map (slave0 and slave2 both hit) -> only o_slv_stb[0] asserts.
- Reset pulled low while in REQ, and separately master drops cyc while in REQ -> strobes go to 0 next edge (asynchronously for reset); no ack; next request serviced normally.
- With macro defined, TIMEOUT_CYC=8, slave never acks -> strobe high 8 cycles, then ack with err=1, dat=0xDEAD_BEEF; ack on cycle 8 instead -> err=0, slave data returned.
